// File: rtl/mat_stream_ctrl_if.sv
// Stream and engine-side signal bundle for mat_stream_ctrl.
// master: the controller's view; slave: the host/engine environment's view.
interface mat_stream_ctrl_if #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 3
);
  logic [width-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [width-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [n*n*width-1:0]   mm_a;
  logic [n*n*width-1:0]   mm_b;
  logic                   mm_start;
  logic [n*n*width-1:0]   mm_c;
  logic                   mm_done;
  logic                   busy;

  modport master (
    input  in_data, in_valid, out_ready, mm_c, mm_done,
    output in_ready, out_data, out_valid, mm_a, mm_b, mm_start, busy
  );

  modport slave (
    output in_data, in_valid, out_ready, mm_c, mm_done,
    input  in_ready, out_data, out_valid, mm_a, mm_b, mm_start, busy
  );
endinterface

// File: rtl/mat_stream_ctrl.sv
// Serial-to-parallel front end and parallel-to-serial back end for the
// matrix-multiply engine: loads A then B element by element, starts the
// engine, waits for a fresh done, captures C and streams it out row-major.
module mat_stream_ctrl #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 3
) (
  input  logic              clk,
  input  logic              rst,
  mat_stream_ctrl_if.master bus
);
  localparam int unsigned   NN   = n * n;
  localparam int unsigned   CW   = $clog2(NN + 1);
  localparam int unsigned   IW   = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [width-1:0] a_q [NN];
  logic [width-1:0] b_q [NN];
  logic [width-1:0] c_q [NN];
  logic             arm_q;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             in_fire, out_fire, cnt_last;

  // Handshake qualifiers; only registered flags gate the transfers
  always_comb begin
    in_fire  = bus.in_valid && in_ready_q;
    out_fire = out_valid_q && bus.out_ready;
    cnt_last = (cnt_q == LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_LOAD_A;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD_A: if (in_fire && cnt_last)       state_d = S_LOAD_B;
      S_LOAD_B: if (in_fire && cnt_last)       state_d = S_START;
      S_START:                                 state_d = S_WAIT;
      S_WAIT:   if (arm_q && bus.mm_done)      state_d = S_UNLOAD;
      S_UNLOAD: if (out_fire && cnt_last)      state_d = S_LOAD_A;
      default:                                 state_d = S_LOAD_A;
    endcase
  end

  // Output decode of the upcoming state, so every flag is a clean register
  always_comb begin
    in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    out_valid_d = (state_d == S_UNLOAD);
    start_d     = (state_d == S_START);
    busy_d      = (state_d == S_START) || (state_d == S_WAIT);
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  // Element counter, operand/result storage and stale-done arm flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
      for (int unsigned i = 0; i < NN; i++) begin
        a_q[IW'(i)] <= '0;
        b_q[IW'(i)] <= '0;
        c_q[IW'(i)] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD_A: if (in_fire) begin
          a_q[cnt_q[IW-1:0]] <= bus.in_data;
          cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
        end
        S_LOAD_B: if (in_fire) begin
          b_q[cnt_q[IW-1:0]] <= bus.in_data;
          cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
        end
        S_START: begin
          arm_q <= 1'b0;
          cnt_q <= '0;
        end
        S_WAIT: begin
          // a done level still high from the previous job must drop first
          if (!bus.mm_done) arm_q <= 1'b1;
          if (arm_q && bus.mm_done) begin
            for (int unsigned i = 0; i < NN; i++)
              c_q[IW'(i)] <= bus.mm_c[i*width +: width];
            cnt_q <= '0;
          end
        end
        S_UNLOAD: if (out_fire) begin
          cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Flatten storage onto the engine buses and drive the stream outputs
  always_comb begin
    bus.mm_a = '0;
    bus.mm_b = '0;
    for (int unsigned i = 0; i < NN; i++) begin
      bus.mm_a[i*width +: width] = a_q[IW'(i)];
      bus.mm_b[i*width +: width] = b_q[IW'(i)];
    end
    bus.out_data  = c_q[cnt_q[IW-1:0]];
    bus.in_ready  = in_ready_q;
    bus.out_valid = out_valid_q;
    bus.mm_start  = start_q;
    bus.busy      = busy_q;
  end
endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Directed bench for mat_stream_ctrl with a behavioural engine and a
// scoreboard of expected C elements.
module tb_mat_stream_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned N  = 3;
  localparam int unsigned NN = 9;

  typedef logic [W-1:0] mat_t [NN];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mat_stream_ctrl_if #(.width(W), .n(N)) bus ();
  mat_stream_ctrl #(.width(W), .n(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  mat_stream_ctrl_if #(.width(8), .n(1)) bus1 ();
  mat_stream_ctrl #(.width(8), .n(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];
  logic [7:0]   exp1_q [$];

  function automatic logic [NN*W-1:0] pack(input mat_t m);
    logic [NN*W-1:0] v;
    v = '0;
    for (int k = 0; k < NN; k++) v[k*W +: W] = m[k];
    return v;
  endfunction

  function automatic logic [NN*W-1:0] matmul(input logic [NN*W-1:0] a, input logic [NN*W-1:0] b);
    logic [NN*W-1:0] r;
    logic [W-1:0] s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s += a[(i*N+k)*W +: W] * b[(k*N+j)*W +: W];
        r[(i*N+j)*W +: W] = s;
      end
    return r;
  endfunction

  // engine for n=3: optional stale done hold, then latency before fresh done
  int   stale_cycles = 0;
  int   eng_lat = 3;
  int   ecnt = 0;
  logic running = 1'b0;
  int   starts = 0;
  always @(posedge clk) begin
    if (bus.mm_start) starts <= starts + 1;
    if (!rst) begin
      bus.mm_done <= 1'b0;
      bus.mm_c    <= '0;
      running     <= 1'b0;
    end else if (bus.mm_start) begin
      running <= 1'b1;
      ecnt    <= 1;
      if (stale_cycles == 0) bus.mm_done <= 1'b0;
    end else if (running) begin
      ecnt <= ecnt + 1;
      if (ecnt == stale_cycles) bus.mm_done <= 1'b0;
      if (ecnt == stale_cycles + eng_lat) begin
        bus.mm_c    <= matmul(bus.mm_a, bus.mm_b);
        bus.mm_done <= 1'b1;
        running     <= 1'b0;
      end
    end
  end

  // engine for n=1, width=8
  int e1 = 0;
  always @(posedge clk) begin
    if (!rst) begin
      bus1.mm_done <= 1'b0;
      bus1.mm_c    <= '0;
      e1           <= 0;
    end else if (bus1.mm_start) begin
      bus1.mm_done <= 1'b0;
      e1           <= 1;
    end else if (e1 != 0) begin
      if (e1 == 2) begin
        bus1.mm_c    <= bus1.mm_a * bus1.mm_b;
        bus1.mm_done <= 1'b1;
        e1           <= 0;
      end else e1 <= e1 + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NN*W-1:0] obs, input logic [NN*W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit rnd);
    int g;
    if (rnd) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 100) begin tick(); g++; end
    chk("in_ready_wait", bus.in_ready, 1);
    tick();
  endtask

  task automatic send_mats(input mat_t a, input mat_t b, input bit rnd);
    for (int k = 0; k < NN; k++) send(a[k], rnd);
    for (int k = 0; k < NN; k++) send(b[k], rnd);
  endtask

  task automatic drain(input int stall_k, input int stall_len);
    logic [W-1:0] e;
    int g;
    int bad_rdy;
    int bad_busy;
    bad_rdy  = 0;
    bad_busy = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NN; k++) begin
      g = 0;
      while (bus.out_valid !== 1'b1 && g < 200) begin
        if (bus.in_ready !== 1'b0) bad_rdy++;
        if (k == 0 && bus.busy !== 1'b1) bad_busy++;
        tick();
        g++;
      end
      chk("out_valid_wait", bus.out_valid, 1);
      if (bus.in_ready !== 1'b0) bad_rdy++;
      if (bus.busy !== 1'b0) bad_busy++;
      e = exp_q.pop_front();
      if (k == stall_k) begin
        bus.out_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, e);
        end
        bus.out_ready = 1'b1;
      end
      chk("out_data", bus.out_data, e);
      tick();
    end
    chk("in_ready_low_while_busy", bad_rdy, 0);
    chk("busy_decode", bad_busy, 0);
    chk("out_valid_after_last", bus.out_valid, 0);
    chk("in_ready_after_last", bus.in_ready, 1);
  endtask

  task automatic job1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int g;
    exp1_q.push_back(c);
    bus1.in_data  = a;
    bus1.in_valid = 1'b1;
    g = 0;
    while (bus1.in_ready !== 1'b1 && g < 100) begin tick(); g++; end
    chk("n1_in_ready_a", bus1.in_ready, 1);
    tick();
    bus1.in_data = b;
    chk("n1_in_ready_b", bus1.in_ready, 1);
    tick();
    bus1.in_valid = 1'b0;
    chk("n1_mm_start", bus1.mm_start, 1);
    chk("n1_mm_a", bus1.mm_a, a);
    chk("n1_mm_b", bus1.mm_b, b);
    g = 0;
    while (bus1.out_valid !== 1'b1 && g < 100) begin tick(); g++; end
    chk("n1_out_valid", bus1.out_valid, 1);
    chk("n1_out_data", bus1.out_data, exp1_q.pop_front());
    tick();
    chk("n1_out_valid_drop", bus1.out_valid, 0);
    chk("n1_in_ready_back", bus1.in_ready, 1);
  endtask

  mat_t ma, mb, mc;
  int   s0;

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mm_start", bus.mm_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mm_a", bus.mm_a, 0);
    chk("rst_mm_b", bus.mm_b, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_n1_in_ready", bus1.in_ready, 0);
    rst = 1'b1;
    tick();
    chk("in_ready_after_rst", bus.in_ready, 1);

    // A=1..9, B=I -> 1..9
    for (int k = 0; k < NN; k++) begin
      ma[k] = W'(k + 1);
      mb[k] = (k % 4 == 0) ? 1 : 0;
      exp_q.push_back(W'(k + 1));
    end
    s0 = starts;
    send_mats(ma, mb, 1'b0);
    bus.in_valid = 1'b0;
    chk("t1_mm_start_pulse", bus.mm_start, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_mm_a", bus.mm_a, pack(ma));
    chk("t1_mm_b", bus.mm_b, pack(mb));
    tick();
    chk("t1_mm_start_one_cycle", bus.mm_start, 0);
    drain(-1, 0);
    chk("t1_start_count", starts, s0 + 1);

    // A=2I, B=1..9, random in_valid, stall mid-unload -> 2,4..18
    for (int k = 0; k < NN; k++) begin
      ma[k] = (k % 4 == 0) ? 2 : 0;
      mb[k] = W'(k + 1);
      exp_q.push_back(W'(2 * (k + 1)));
    end
    send_mats(ma, mb, 1'b1);
    bus.in_valid = 1'b0;
    drain(4, 5);

    // stale done held 2 cycles after start, fresh done 4 cycles later
    stale_cycles = 2;
    eng_lat      = 4;
    for (int k = 0; k < NN; k++) begin
      ma[k] = W'(k + 1);
      mb[k] = 1;
    end
    mc = matmul(pack(ma), pack(mb)) == '0 ? ma : ma;
    for (int k = 0; k < NN; k++) exp_q.push_back(W'(6 + 9 * (k / 3)));
    send_mats(ma, mb, 1'b0);
    bus.in_valid = 1'b0;
    drain(-1, 0);
    stale_cycles = 0;
    eng_lat      = 3;

    // reset mid-load of A
    s0 = starts;
    for (int k = 0; k < 5; k++) send(W'(100 + k), 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_mm_a", bus.mm_a, 0);
    chk("abort_mm_start", bus.mm_start, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    rst = 1'b1;
    tick();
    chk("abort_no_start", starts, s0);
    for (int k = 0; k < NN; k++) begin
      ma[k] = W'(11 + k);
      mb[k] = (k % 4 == 0) ? 1 : 0;
      exp_q.push_back(W'(11 + k));
    end
    send_mats(ma, mb, 1'b0);
    bus.in_valid = 1'b0;
    chk("abort_new_mm_a", bus.mm_a, pack(ma));
    drain(-1, 0);
    chk("abort_start_count", starts, s0 + 1);

    // back-to-back jobs with in_valid held high
    for (int k = 0; k < NN; k++) begin
      ma[k] = W'(9 - k);
      mb[k] = (k % 4 == 0) ? 1 : 0;
      exp_q.push_back(W'(9 - k));
    end
    send_mats(ma, mb, 1'b0);
    bus.in_data = 3;
    drain(-1, 0);
    for (int k = 0; k < NN; k++) begin
      ma[k] = (k % 4 == 0) ? 3 : 0;
      mb[k] = W'(k + 1);
      exp_q.push_back(W'(3 * (k + 1)));
    end
    send_mats(ma, mb, 1'b0);
    bus.in_valid = 1'b0;
    chk("b2b_mm_a", bus.mm_a, pack(ma));
    chk("b2b_mm_b", bus.mm_b, pack(mb));
    drain(-1, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // n=1, width=8
    job1(8'd7, 8'd6, 8'd42);
    job1(8'd3, 8'd5, 8'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
